// File: rtl/cs3220_io_pkg.sv
// Shared definitions for the board I/O window: register offsets, field widths
// and the byte-lane merge used by every writable register.
package cs3220_io_pkg;

    localparam int LEDR_W = 10;
    localparam int HEX_W  = 24;
    localparam int KEY_W  = 4;
    localparam int SW_W   = 10;

    localparam int TCTL_EN  = 0;
    localparam int TCTL_RDY = 1;

    // Word index inside the 32-byte window (byte offset >> 2).
    typedef enum logic [2:0] {
        IO_LEDR    = 3'd0,
        IO_HEX     = 3'd1,
        IO_KEY     = 3'd2,
        IO_KEYEDGE = 3'd3,
        IO_SW      = 3'd4,
        IO_TCNT    = 3'd5,
        IO_TLIM    = 3'd6,
        IO_TCTL    = 3'd7
    } io_reg_e;

    function automatic logic [31:0] merge_sel(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                r[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/io_timer.sv
// Millisecond timer: prescaler, count, limit, enable and sticky ready flag.
// Bus writes to the count override a simultaneous tick; a ready set beats its clear.
module io_timer
    import cs3220_io_pkg::*;
#(
    parameter int CLK_PER_MS = 50000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cnt_wr_i,
    input  logic        lim_wr_i,
    input  logic        ctl_wr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] cnt_o,
    output logic [31:0] lim_o,
    output logic        en_o,
    output logic        rdy_o
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   lim_q, lim_d;
    logic          en_q, en_d;
    logic          rdy_q, rdy_d;
    logic          tick;
    logic          wrap;
    logic          rdy_set;
    logic          rdy_clr;

    // The tick is qualified by the registered enable, so an enable write in
    // the same cycle only affects later ticks.
    assign tick = en_q && (presc_q == PRESC_LAST);
    assign wrap = (lim_q != 32'd0) && (cnt_q == lim_q - 32'd1);

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        en_d    = en_q;
        rdy_set = 1'b0;
        rdy_clr = 1'b0;

        if (!en_q || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (tick) begin
            if (wrap) begin
                cnt_d   = 32'd0;
                rdy_set = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        if (cnt_wr_i) begin
            cnt_d = merge_sel(cnt_q, wdata_i, sel_i);
        end
        if (lim_wr_i) begin
            lim_d = merge_sel(lim_q, wdata_i, sel_i);
        end
        if (ctl_wr_i && sel_i[0]) begin
            en_d    = wdata_i[TCTL_EN];
            rdy_clr = wdata_i[TCTL_RDY];
        end

        rdy_d = (rdy_q && !rdy_clr) || rdy_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            cnt_q   <= 32'd0;
            lim_q   <= 32'd0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
        end
    end

    assign cnt_o = cnt_q;
    assign lim_o = lim_q;
    assign en_o  = en_q;
    assign rdy_o = rdy_q;

endmodule

// File: rtl/wb_io_slave.sv
// Wishbone pipelined slave for the board I/O window (LEDs, HEX, switches,
// keys, timer). Every accepted request gets exactly one ack or err a cycle later.
module wb_io_slave
    import cs3220_io_pkg::*;
#(
    parameter logic [31:0] IO_BASE    = 32'hF000_0000,
    parameter int          CLK_PER_MS = 50000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [29:0]       wb_addr,
    input  logic [3:0]        wb_sel,
    input  logic [31:0]       wb_mosi,
    output logic [31:0]       wb_miso,
    output logic              wb_ack,
    output logic              wb_err,
    output logic              wb_stall,
    input  logic [SW_W-1:0]   i_sw,
    input  logic [KEY_W-1:0]  i_key,
    output logic [LEDR_W-1:0] o_ledr,
    output logic [HEX_W-1:0]  o_hex
);

    io_reg_e off;
    logic    req;
    logic    hit;
    logic    wr_hit;

    assign off    = io_reg_e'(wb_addr[2:0]);
    assign req    = wb_cyc && wb_stb;
    assign hit    = (wb_addr[29:3] == IO_BASE[31:5]);
    assign wr_hit = req && hit && wb_we;

    logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
    logic [KEY_W-1:0]  key_s1_q, key_s2_q, key_s3_q;
    logic [KEY_W-1:0]  key_pressed;
    logic [KEY_W-1:0]  key_press_evt;
    logic [KEY_W-1:0]  keyedge_q, keyedge_d;
    logic [KEY_W-1:0]  keyedge_clr;
    logic [LEDR_W-1:0] ledr_q, ledr_d;
    logic [HEX_W-1:0]  hex_q, hex_d;
    logic [31:0]       ledr_m, hex_m;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       miso_q, miso_d;
    logic [31:0]       rdata;

    logic [31:0] tmr_cnt, tmr_lim;
    logic        tmr_en, tmr_rdy;

    // key_s3_q is the previous synced sample; reset leaves s2 == s3 so no
    // spurious press is captured while the synchronizers fill.
    assign key_pressed   = ~key_s2_q;
    assign key_press_evt = ~key_s2_q & key_s3_q;

    io_timer #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_timer (
        .clk_i   (i_clk),
        .rst_ni  (i_reset_n),
        .cnt_wr_i(wr_hit && (off == IO_TCNT)),
        .lim_wr_i(wr_hit && (off == IO_TLIM)),
        .ctl_wr_i(wr_hit && (off == IO_TCTL)),
        .sel_i   (wb_sel),
        .wdata_i (wb_mosi),
        .cnt_o   (tmr_cnt),
        .lim_o   (tmr_lim),
        .en_o    (tmr_en),
        .rdy_o   (tmr_rdy)
    );

    always_comb begin
        case (off)
            IO_LEDR:    rdata = 32'(ledr_q);
            IO_HEX:     rdata = 32'(hex_q);
            IO_KEY:     rdata = 32'(key_pressed);
            IO_KEYEDGE: rdata = 32'(keyedge_q);
            IO_SW:      rdata = 32'(sw_s2_q);
            IO_TCNT:    rdata = tmr_cnt;
            IO_TLIM:    rdata = tmr_lim;
            IO_TCTL:    rdata = {30'd0, tmr_rdy, tmr_en};
            default:    rdata = 32'd0;
        endcase
    end

    always_comb begin
        ledr_m      = merge_sel(32'(ledr_q), wb_mosi, wb_sel);
        hex_m       = merge_sel(32'(hex_q), wb_mosi, wb_sel);
        ledr_d      = ledr_q;
        hex_d       = hex_q;
        keyedge_clr = '0;

        if (wr_hit && (off == IO_LEDR)) begin
            ledr_d = ledr_m[LEDR_W-1:0];
        end
        if (wr_hit && (off == IO_HEX)) begin
            hex_d = hex_m[HEX_W-1:0];
        end
        if (wr_hit && (off == IO_KEYEDGE) && wb_sel[0]) begin
            keyedge_clr = wb_mosi[KEY_W-1:0];
        end

        // A press captured in the same cycle as its clear must survive.
        keyedge_d = (keyedge_q & ~keyedge_clr) | key_press_evt;

        ack_d  = req && hit;
        err_d  = req && !hit;
        miso_d = (req && hit && !wb_we) ? rdata : 32'd0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            key_s1_q  <= '0;
            key_s2_q  <= '0;
            key_s3_q  <= '0;
            keyedge_q <= '0;
            ledr_q    <= '0;
            hex_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            miso_q    <= 32'd0;
        end else begin
            sw_s1_q   <= i_sw;
            sw_s2_q   <= sw_s1_q;
            key_s1_q  <= i_key;
            key_s2_q  <= key_s1_q;
            key_s3_q  <= key_s2_q;
            keyedge_q <= keyedge_d;
            ledr_q    <= ledr_d;
            hex_q     <= hex_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            miso_q    <= miso_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_err   = err_q;
    assign wb_miso  = miso_q;
    assign wb_stall = 1'b0;
    assign o_ledr   = ledr_q;
    assign o_hex    = hex_q;

endmodule

// File: tb/tb_wb_io_slave.sv
// Scoreboard bench for wb_io_slave: each request queues its expected response,
// a negedge monitor pops and compares whatever the slave returns.
module tb_wb_io_slave;

    localparam int          CPM  = 4;
    localparam logic [31:0] BASE = 32'hF000_0000;
    localparam logic [31:0] A_LEDR    = BASE + 32'h00;
    localparam logic [31:0] A_HEX     = BASE + 32'h04;
    localparam logic [31:0] A_KEY     = BASE + 32'h08;
    localparam logic [31:0] A_KEYEDGE = BASE + 32'h0C;
    localparam logic [31:0] A_SW      = BASE + 32'h10;
    localparam logic [31:0] A_TCNT    = BASE + 32'h14;
    localparam logic [31:0] A_TLIM    = BASE + 32'h18;
    localparam logic [31:0] A_TCTL    = BASE + 32'h1C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [29:0] wb_addr = '0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_mosi = '0;
    logic [31:0] wb_miso;
    logic        wb_ack, wb_err, wb_stall;
    logic [9:0]  i_sw = 10'h2A5;
    logic [3:0]  i_key = 4'hF;
    logic [9:0]  o_ledr;
    logic [23:0] o_hex;

    typedef struct {
        int          due;
        int          id;
        logic        ack;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   id_ctr = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    wb_io_slave #(
        .IO_BASE   (BASE),
        .CLK_PER_MS(CPM)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_sel   (wb_sel),
        .wb_mosi  (wb_mosi),
        .wb_miso  (wb_miso),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err),
        .wb_stall (wb_stall),
        .i_sw     (i_sw),
        .i_key    (i_key),
        .o_ledr   (o_ledr),
        .o_hex    (o_hex)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check_eq($sformatf("rsp#%0d", e.id),
                         64'({wb_ack, wb_err, wb_miso}),
                         64'({e.ack, e.err, e.data}));
            end else if (wb_ack || wb_err) begin
                check_eq("spurious_rsp", 64'({wb_ack, wb_err}), 64'd0);
            end
        end
    end

    task automatic bus(input logic we, input logic [31:0] baddr, input logic [3:0] sel,
                       input logic [31:0] wdat, input logic experr, input logic [31:0] exprd);
        exp_t e;
        @(negedge clk);
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        wb_we   = we;
        wb_addr = baddr[31:2];
        wb_sel  = sel;
        wb_mosi = wdat;
        e.due  = cyc + 1;
        e.id   = id_ctr;
        e.ack  = !experr;
        e.err  = experr;
        e.data = (we || experr) ? 32'd0 : exprd;
        id_ctr++;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        bus(1'b0, a, 4'hF, 32'd0, 1'b0, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
        bus(1'b1, a, sel, d, 1'b0, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wb_cyc = 1'b0;
            wb_stb = 1'b0;
            wb_we  = 1'b0;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] expc;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ack",  64'(wb_ack),  64'd0);
        check_eq("rst_err",  64'(wb_err),  64'd0);
        check_eq("rst_miso", 64'(wb_miso), 64'd0);
        check_eq("rst_ledr", 64'(o_ledr),  64'd0);
        check_eq("rst_hex",  64'(o_hex),   64'd0);
        check_eq("rst_stall", 64'(wb_stall), 64'd0);
        rst_n = 1'b1;
        idle(4);

        // LEDR write / read-back, partial byte lane
        wr(A_LEDR, 4'hF, 32'h0000_03FF);
        idle(1);
        check_eq("ledr_out", 64'(o_ledr), 64'h3FF);
        rd(A_LEDR, 32'h0000_03FF);
        wr(A_LEDR, 4'b0001, 32'h0000_0000);
        rd(A_LEDR, 32'h0000_0300);
        wr(A_LEDR, 4'hF, 32'h0000_03FF);

        // HEX byte-lane write, back-to-back read
        wr(A_HEX, 4'b0010, 32'h00AA_BBCC);
        rd(A_HEX, 32'h0000_BB00);
        idle(1);
        check_eq("hex_out", 64'(o_hex), 64'h00BB00);

        // Out-of-window accesses error and have no side effect
        bus(1'b0, 32'hF000_0020, 4'hF, 32'd0, 1'b1, 32'd0);
        bus(1'b0, 32'h0000_1000, 4'hF, 32'd0, 1'b1, 32'd0);
        bus(1'b1, 32'hF000_0020, 4'hF, 32'd0, 1'b1, 32'd0);
        bus(1'b1, 32'hF000_0024, 4'hF, 32'd0, 1'b1, 32'd0);
        idle(1);
        check_eq("err_ledr_kept", 64'(o_ledr), 64'h3FF);
        check_eq("err_hex_kept",  64'(o_hex),  64'h00BB00);

        // Strobe without cycle: not accepted
        @(negedge clk);
        wb_cyc  = 1'b0;
        wb_stb  = 1'b1;
        wb_we   = 1'b1;
        wb_addr = A_LEDR[31:2];
        wb_sel  = 4'hF;
        wb_mosi = 32'd0;
        idle(2);
        check_eq("nocyc_ledr", 64'(o_ledr), 64'h3FF);

        // Switches are read-only
        rd(A_SW, 32'h0000_02A5);
        wr(A_SW, 4'hF, 32'h0000_0000);
        rd(A_SW, 32'h0000_02A5);

        // Keys and sticky press capture
        idle(1);
        i_key = 4'b1011;
        idle(10);
        rd(A_KEY, 32'h4);
        rd(A_KEYEDGE, 32'h4);
        wr(A_KEYEDGE, 4'h1, 32'h4);
        rd(A_KEYEDGE, 32'h0);
        rd(A_KEY, 32'h4);
        idle(1);
        i_key = 4'hF;
        idle(5);
        rd(A_KEY, 32'h0);
        rd(A_KEYEDGE, 32'h0);
        idle(1);
        i_key = 4'b1011;
        idle(5);
        rd(A_KEYEDGE, 32'h4);
        wr(A_KEYEDGE, 4'h1, 32'hF);
        idle(1);
        i_key = 4'hF;
        idle(4);
        rd(A_KEYEDGE, 32'h0);

        // Timer with limit 3: enable write is accepted at edge 0,
        // the read accepted at edge k sees the count after edge k-1.
        wr(A_TLIM, 4'hF, 32'd3);
        wr(A_TCTL, 4'h1, 32'h1);
        for (int k = 1; k <= 23; k++) begin
            if (k == 12)      rd(A_TCTL, 32'h1);
            else if (k == 13) rd(A_TCTL, 32'h3);
            else              rd(A_TCNT, 32'(((k - 1) / CPM) % 3));
        end
        wr(A_TCTL, 4'h1, 32'h3);      // k=24: clear rdy on the wrap tick
        rd(A_TCTL, 32'h3);            // k=25
        wr(A_TCTL, 4'h1, 32'h2);      // k=26: disable and clear rdy
        rd(A_TCTL, 32'h0);            // k=27
        rd(A_TCNT, 32'h0);            // k=28
        rd(A_TLIM, 32'h3);            // k=29

        // Free-running wrap, write-vs-tick and enable-vs-tick
        wr(A_TLIM, 4'hF, 32'd0);
        wr(A_TCNT, 4'hF, 32'hFFFF_FFFE);
        wr(A_TCTL, 4'h1, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            if (k - 1 < 4)      expc = 32'hFFFF_FFFE;
            else if (k - 1 < 8) expc = 32'hFFFF_FFFF;
            else                expc = 32'h0;
            rd(A_TCNT, expc);
        end
        rd(A_TCTL, 32'h1);            // k=10: wrap to 0 without rdy
        rd(A_TCNT, 32'h0);            // k=11
        wr(A_TCNT, 4'hF, 32'h55);     // k=12: tick edge, write wins
        rd(A_TCNT, 32'h55);           // k=13
        rd(A_TCNT, 32'h55);           // k=14
        rd(A_TCNT, 32'h55);           // k=15
        wr(A_TCTL, 4'h1, 32'h0);      // k=16: tick still uses old enable
        rd(A_TCNT, 32'h56);           // k=17
        rd(A_TCNT, 32'h56);           // k=18
        idle(2);

        // Reset while a response is pending
        @(negedge clk);
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        wb_we   = 1'b0;
        wb_addr = A_LEDR[31:2];
        wb_sel  = 4'hF;
        @(posedge clk);
        #1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        check_eq("pend_ack", 64'(wb_ack), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_ack",  64'(wb_ack),  64'd0);
        check_eq("arst_err",  64'(wb_err),  64'd0);
        check_eq("arst_miso", 64'(wb_miso), 64'd0);
        check_eq("arst_ledr", 64'(o_ledr),  64'd0);
        check_eq("arst_hex",  64'(o_hex),   64'd0);
        repeat (2) @(negedge clk);
        check_eq("rst_no_rsp", 64'({wb_ack, wb_err}), 64'd0);
        rst_n = 1'b1;
        idle(4);
        rd(A_TCNT, 32'h0);
        rd(A_TLIM, 32'h0);
        rd(A_TCTL, 32'h0);
        rd(A_KEYEDGE, 32'h0);
        rd(A_KEY, 32'h0);
        rd(A_HEX, 32'h0);
        rd(A_SW, 32'h0000_02A5);
        idle(3);

        check_eq("sb_drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_io_slave.md
Name: wb_io_slave

Overview:
- Wishbone pipelined slave on the core's data-bus master port (wb_cyc/wb_stb/wb_we/wb_addr/wb_sel/wb_mosi → wb_miso/wb_ack/wb_stall/wb_err).
- Provides the memory-mapped board I/O window: LEDs, 7-segment HEX, switches, keys with sticky press capture, and a millisecond timer.
- Any access that misses the window or hits an unmapped offset is answered with wb_err, so the memory stage always receives a response.

Parameters:
- IO_BASE, 32'hF000_0000, byte base address of the 32-byte register window; bits [4:0] must be zero.
- CLK_PER_MS, 50000, i_clk cycles per timer tick; must be ≥2.

Ports:
- i_clk  in  1  core clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- wb_cyc  in  1  bus cycle.
- wb_stb  in  1  request strobe.
- wb_we  in  1  write enable.
- wb_addr  in  30  word address (byte address >> 2).
- wb_sel  in  4  byte lanes for writes.
- wb_mosi  in  32  write data.
- wb_miso  out  32  read data.
- wb_ack  out  1  success response.
- wb_err  out  1  error response.
- wb_stall  out  1  constant 0; every request is accepted.
- i_sw  in  10  raw switches, asynchronous.
- i_key  in  4  raw keys, asynchronous, active-low.
- o_ledr  out  10  LED register.
- o_hex  out  24  HEX register, 4 bits per digit.

Behaviour:
- Reset (async assert, sync release): wb_ack=0, wb_err=0, wb_miso=0, o_ledr=0, o_hex=0, key_edge=0, timer cnt=0, limit=0, en=0, rdy=0, prescaler=0, synchronizers=0.
- A request is accepted when wb_cyc&&wb_stb. Hit means wb_addr[29:3]==IO_BASE[31:5] and the offset is mapped.
- Exactly one cycle after acceptance, exactly one of wb_ack/wb_err pulses high for one cycle, with wb_miso valid alongside. Back-to-back requests give back-to-back responses.
- If wb_cyc is low when a request would be accepted, nothing is accepted and no response follows.
- wb_miso=0 on writes and on errors. Errored writes have no side effect.
- Register map (byte offsets; word index = wb_addr[2:0]):
  - 0x00 LEDR: RW, bits [9:0].
  - 0x04 HEX: RW, bits [23:0].
  - 0x08 KEY: RO, pressed state = ~synced i_key.
  - 0x0C KEYEDGE: sticky press bits, write-1-to-clear.
  - 0x10 SW: RO, synced i_sw.
  - 0x14 TCNT: RW.
  - 0x18 TLIM: RW.
  - 0x1C TCTL: bit0 en (RW), bit1 rdy (sticky, W1C).
  - All 8 offsets are mapped. Any address outside the window errors. A write to an RO register acks and is ignored.
- Writes honour wb_sel per byte lane. Unimplemented bits read 0.
- Synchronization:
  - i_sw and i_key each pass through 2 flops; read visibility lag ≤3 cycles.
  - KEYEDGE[n] sets when pressed[n] transitions 0→1 in the synced domain.
- Timer:
  - Prescaler counts 0..CLK_PER_MS-1 only while en=1, and is cleared whenever en=0. Its terminal count produces a tick.
  - On a tick: if TLIM≠0 and cnt==TLIM-1, then cnt←0 and rdy←1. Otherwise cnt←cnt+1, wrapping 2^32-1 to 0 with no rdy.
  - TLIM=0 means free-running.
- Same-cycle collisions:
  - Bus write to TCNT and a tick: the write wins.
  - W1C of rdy or KEYEDGE and a set event: the set wins (bit stays 1).
  - Write to TCTL.en and a tick: the tick uses the old en.
- Reset mid-transaction: a pending response is dropped; wb_ack and wb_err are 0 immediately.

Decomposition:
- Package cs3220_io_pkg: register offset constants (IO_LEDR..IO_TCTL), field widths (LEDR_W=10, HEX_W=24, KEY_W=4, SW_W=10), TCTL bit positions.
- One sub-module, io_timer: prescaler, cnt, limit, en, rdy, and the write/W1C ports with the tick-vs-write priority.
- The bus decode and the other registers stay in wb_io_slave.

Test Plan:
- Reset, then write 0x3FF sel=4'b1111 to 0xF000_0000 → ack exactly 1 cycle later, o_ledr=10'h3FF. Read back → wb_miso=0x0000_03FF.
- Write 0xAABBCC with sel=4'b0010 to HEX → o_hex=24'h00BB00. Back-to-back read of HEX on the next cycle → ack in consecutive cycles.
- Read 0xF000_0020 and 0x0000_1000 → wb_err pulse, wb_ack=0, wb_miso=0, no register changes.
- Hold i_key[2] low for 10 cycles → KEY reads 0x4 and KEYEDGE reads 0x4. Write 0x4 to KEYEDGE while the key is held → reads 0. Release then press again → KEYEDGE=0x4.
- CLK_PER_MS=4, TLIM=3, en=1 → cnt steps 0,1,2,0 every 4 cycles and rdy=1 after 12 cycles. W1C in the same cycle as the next wrap → rdy stays 1.
- Assert i_reset_n=0 one cycle after a request → no ack. All outputs and registers return to reset values asynchronously.
